// File: rtl/mio_responder_pkg.sv
// Shared address map, FSM encoding and address decoder for the memory-mapped I/O responder.
package mio_responder_pkg;

    localparam logic [31:0] RAM_BASE = 32'h0000_0000;
    localparam logic [31:0] LED_ADDR = 32'hF000_0000;
    localparam logic [31:0] SW_ADDR  = 32'hF000_0004;
    localparam logic [31:0] CNT_ADDR = 32'hF000_0008;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [2:0] {
        SelNone,
        SelRam,
        SelLed,
        SelSw,
        SelCnt
    } sel_e;

    // Byte-offset bits [1:0] never take part in the match.
    function automatic sel_e decode_addr(input logic [31:0] addr, input int unsigned ram_aw);
        if ((addr >> (ram_aw + 2)) == (RAM_BASE >> (ram_aw + 2))) return SelRam;
        if (addr[31:2] == LED_ADDR[31:2]) return SelLed;
        if (addr[31:2] == SW_ADDR[31:2]) return SelSw;
        if (addr[31:2] == CNT_ADDR[31:2]) return SelCnt;
        return SelNone;
    endfunction

endpackage

// File: rtl/mio_ram.sv
// Word-addressed data RAM: synchronous write, combinational read port sampled by the responder.
module mio_ram #(
    parameter int unsigned RAM_WORDS = 256,
    parameter int unsigned ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [RAM_WORDS];

    // Contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mio_responder.sv
// Four-phase handshake responder serving RAM, LED, switch and counter registers.
module mio_responder
    import mio_responder_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned RAM_WORDS   = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CPU_MIO,
    input  logic        mem_w,
    input  logic [31:0] Addr_in,
    input  logic [31:0] Data_in,
    output logic [31:0] Data_out,
    output logic        MIO_ready,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic        bus_err
);

    localparam int unsigned RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [31:0] addr_q, wdata_q;
    logic        we_q;
    logic [15:0] led_q;
    logic [31:0] cnt_q;
    logic [31:0] dout_q;
    logic        bus_err_q;

    logic        do_access;
    logic [31:0] acc_addr, acc_wdata;
    logic        acc_we;
    sel_e        acc_sel;
    logic [31:0] ram_rdata;
    logic [31:0] rd_val;
    logic        ram_we;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        do_access = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (CPU_MIO) begin
                    wait_d = 4'd0;
                    if (WAIT_CYCLES == 0) begin
                        state_d   = ST_ACK;
                        do_access = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d   = ST_ACK;
                    do_access = 1'b1;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            ST_ACK:  state_d = ST_DONE;
            ST_DONE: begin
                if (!CPU_MIO) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // With zero wait cycles the access happens on the sampling edge, so bypass the latches.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_addr  = Addr_in;
            acc_wdata = Data_in;
            acc_we    = mem_w;
        end else begin
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_we    = we_q;
        end
        acc_sel = decode_addr(acc_addr, RAM_AW);
        ram_we  = do_access && acc_we && (acc_sel == SelRam);
    end

    always_comb begin
        rd_val = 32'd0;
        case (acc_sel)
            SelRam:  rd_val = ram_rdata;
            SelLed:  rd_val = {16'd0, led_q};
            SelSw:   rd_val = {16'd0, sw};
            SelCnt:  rd_val = cnt_q;
            default: rd_val = 32'd0;
        endcase
    end

    mio_ram #(
        .RAM_WORDS (RAM_WORDS),
        .ADDR_W    (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (acc_addr[RAM_AW+1:2]),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            wait_q    <= 4'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            we_q      <= 1'b0;
            led_q     <= 16'd0;
            cnt_q     <= 32'd0;
            dout_q    <= 32'd0;
            bus_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q == ST_IDLE && CPU_MIO) begin
                addr_q  <= Addr_in;
                wdata_q <= Data_in;
                we_q    <= mem_w;
            end
            if (do_access && acc_we && acc_sel == SelLed) begin
                led_q <= acc_wdata[15:0];
            end
            if (do_access && acc_we && acc_sel == SelCnt) begin
                cnt_q <= acc_wdata;
            end else begin
                cnt_q <= cnt_q + 32'd1;
            end
            if (do_access && !acc_we) begin
                dout_q <= rd_val;
            end
            if (do_access && acc_sel == SelNone) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    assign MIO_ready = (state_q == ST_ACK);
    assign Data_out  = dout_q;
    assign led       = led_q;
    assign bus_err   = bus_err_q;

endmodule
